// File: rtl/ma_rw_stage.sv
// ma_rw_stage: memory-access and register-writeback back end of the SimpleRisc
// pipeline. Holds the EX/MA and MA/RW latches, runs the data-memory
// request/ready handshake, drives the register-file write port and the
// forwarding taps, and stalls EX while a load/store waits on memory.
module ma_rw_stage #(
  parameter int CB_W      = 22,
  parameter int CB_ISST   = 0,
  parameter int CB_ISLD   = 1,
  parameter int CB_ISWB   = 6,
  parameter int CB_ISCALL = 8,
  parameter int RA_REG    = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [31:0]     output_EX_PC,
  input  logic [31:0]     ALU_Result,
  input  logic [31:0]     EX_op2,
  input  logic [31:0]     output_EX_IR,
  input  logic [CB_W-1:0] output_EX_controlBus,
  output logic            stall_out,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic            fwd_ma_valid,
  output logic [3:0]      fwd_ma_rd,
  output logic            fwd_ma_isld,
  output logic            fwd_rw_valid,
  output logic [3:0]      fwd_rw_rd,
  output logic [31:0]     fwd_rw_data,
  output logic [31:0]     retire_count
);

  typedef enum logic {MA_IDLE = 1'b0, MA_REQ = 1'b1} ma_state_t;

  ma_state_t       state_reg, state_next;

  // EX/MA latch
  logic            ma_valid_reg;
  logic [31:0]     ma_pc_reg;
  logic [31:0]     ma_alu_reg;
  logic [31:0]     ma_op2_reg;
  logic [31:0]     ma_ir_reg;
  logic [CB_W-1:0] ma_cb_reg;

  // MA/RW latch
  logic            rw_valid_reg;
  logic            rw_iswb_reg;
  logic [3:0]      rw_waddr_reg;
  logic [31:0]     rw_data_reg;
  logic [31:0]     retire_count_reg;

  logic            ex_is_mem;
  logic            ma_isld;
  logic            ma_iscall;
  logic [3:0]      ma_rd;
  logic [31:0]     ma_result;

  assign ex_is_mem = output_EX_controlBus[CB_ISLD] | output_EX_controlBus[CB_ISST];
  assign ma_isld   = ma_cb_reg[CB_ISLD];
  assign ma_iscall = ma_cb_reg[CB_ISCALL];
  // Calls write the return address register instead of the IR rd field.
  assign ma_rd     = ma_iscall ? 4'(RA_REG) : ma_ir_reg[25:22];
  assign ma_result = ma_isld   ? mem_rdata
                   : ma_iscall ? ma_pc_reg + 32'd4
                   : ma_alu_reg;

  // Next state, stall and memory-port outputs; the port is only driven in MA_REQ.
  always_comb begin
    state_next = state_reg;
    stall_out  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    if (state_reg == MA_REQ) begin
      stall_out = ~mem_ready;
      mem_req   = 1'b1;
      mem_we    = ma_cb_reg[CB_ISST];
      mem_addr  = ma_alu_reg;
      mem_wdata = ma_op2_reg;
    end
    if (!stall_out) begin
      // A bubble never issues a memory request whatever its control bits say.
      state_next = (ex_valid && ex_is_mem) ? MA_REQ : MA_IDLE;
    end
  end

  // State register, pipeline latches and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= MA_IDLE;
      ma_valid_reg     <= 1'b0;
      ma_pc_reg        <= 32'd0;
      ma_alu_reg       <= 32'd0;
      ma_op2_reg       <= 32'd0;
      ma_ir_reg        <= 32'd0;
      ma_cb_reg        <= '0;
      rw_valid_reg     <= 1'b0;
      rw_iswb_reg      <= 1'b0;
      rw_waddr_reg     <= 4'd0;
      rw_data_reg      <= 32'd0;
      retire_count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (!stall_out) begin
        ma_valid_reg <= ex_valid;
        ma_pc_reg    <= output_EX_PC;
        ma_alu_reg   <= ALU_Result;
        ma_op2_reg   <= EX_op2;
        ma_ir_reg    <= output_EX_IR;
        ma_cb_reg    <= output_EX_controlBus;
        rw_valid_reg <= ma_valid_reg;
        rw_iswb_reg  <= ma_cb_reg[CB_ISWB];
        rw_waddr_reg <= ma_rd;
        rw_data_reg  <= ma_result;
      end else begin
        // Bubble into RW while MA waits so the instruction is written back once.
        rw_valid_reg <= 1'b0;
      end
      if (rw_valid_reg) begin
        retire_count_reg <= retire_count_reg + 32'd1;
      end
    end
  end

  assign rf_we        = rw_valid_reg & rw_iswb_reg;
  assign rf_waddr     = rw_waddr_reg;
  assign rf_wdata     = rw_data_reg;
  assign retire_count = retire_count_reg;

  // A load sitting in MA has no data yet; fwd_ma_isld tells upstream to interlock.
  assign fwd_ma_valid = ma_valid_reg & ma_cb_reg[CB_ISWB];
  assign fwd_ma_rd    = ma_rd;
  assign fwd_ma_isld  = ma_isld;

  assign fwd_rw_valid = rf_we;
  assign fwd_rw_rd    = rf_waddr;
  assign fwd_rw_data  = rf_wdata;

endmodule

// File: tb/tb_ma_rw_stage.sv
// Bench for ma_rw_stage: table of single instructions plus hand-written
// reset-abort and back-to-back load sequences; register writes are checked
// against a queue of expected writebacks.
module tb_ma_rw_stage;

  localparam logic [21:0] CB_NONE = 22'h0;
  localparam logic [21:0] CB_ADD  = 22'h000040;
  localparam logic [21:0] CB_LD   = 22'h000042;
  localparam logic [21:0] CB_ST   = 22'h000001;
  localparam logic [21:0] CB_CALL = 22'h000140;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_pc, alu_result, ex_op2, ex_ir;
  logic [21:0] ex_cb;
  logic        stall_out, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_ma_valid, fwd_ma_isld, fwd_rw_valid;
  logic [3:0]  fwd_ma_rd, fwd_rw_rd;
  logic [31:0] fwd_rw_data, retire_count;

  ma_rw_stage dut (
    .clk(clk), .reset(rst_n), .ex_valid(ex_valid),
    .output_EX_PC(ex_pc), .ALU_Result(alu_result), .EX_op2(ex_op2),
    .output_EX_IR(ex_ir), .output_EX_controlBus(ex_cb),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_ma_valid(fwd_ma_valid), .fwd_ma_rd(fwd_ma_rd), .fwd_ma_isld(fwd_ma_isld),
    .fwd_rw_valid(fwd_rw_valid), .fwd_rw_rd(fwd_rw_rd), .fwd_rw_data(fwd_rw_data),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] op2;
    logic [3:0]  rd;
    logic [21:0] cb;
    int          wait_cyc;
    logic [31:0] rdata;
    logic        exp_mem;
    logic        exp_we;
    logic [3:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [3:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  vec_t        vecs[8];
  wb_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] ret_exp = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] op2, input logic [3:0] rd, input logic [21:0] cb);
    ex_valid   = v;
    ex_pc      = pc;
    alu_result = alu;
    ex_op2     = op2;
    ex_ir      = {6'd0, rd, 22'd0};
    ex_cb      = cb;
  endtask

  // Issue one instruction, serve its memory access, then drain the pipe.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive_ex(v.valid, v.pc, v.alu, v.op2, v.rd, v.cb);
    mem_ready = 1'b0;
    if (v.exp_we) exp_q.push_back('{v.exp_waddr, v.exp_wdata});
    @(negedge clk);
    drive_ex(1'b0, 32'd0, 32'd0, 32'd0, 4'd0, CB_NONE);
    if (v.exp_mem) begin
      check("mem_req", {31'd0, mem_req}, 32'd1);
      check("mem_we", {31'd0, mem_we}, {31'd0, v.cb[0]});
      check("mem_addr", mem_addr, v.alu);
      check("mem_wdata", mem_wdata, v.op2);
      for (int w = 0; w < v.wait_cyc; w++) begin
        check("stall_wait", {31'd0, stall_out}, 32'd1);
        check("mem_addr_hold", mem_addr, v.alu);
        check("mem_we_hold", {31'd0, mem_we}, {31'd0, v.cb[0]});
        @(negedge clk);
      end
      mem_ready = 1'b1;
      mem_rdata = v.rdata;
      #1;
      check("stall_release", {31'd0, stall_out}, 32'd0);
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
    end else begin
      check("no_mem_req", {31'd0, mem_req}, 32'd0);
      check("no_stall", {31'd0, stall_out}, 32'd0);
    end
    if (v.valid) ret_exp = ret_exp + 32'd1;
    @(negedge clk);
    @(negedge clk);
    check("retire_count", retire_count, ret_exp);
    $display("[TB] vec %0d done: retire_count=%0d", idx, retire_count);
  endtask

  initial begin
    //         valid  pc            alu           op2           rd    cb       wt  rdata         mem   we    waddr wdata
    vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0010, 32'h0,        4'd3, CB_ADD,  0, 32'h0,        1'b0, 1'b1, 4'd3,  32'h0000_0010};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h0000_0040, 32'h0,        4'd5, CB_LD,   3, 32'hDEADBEEF, 1'b1, 1'b1, 4'd5,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h0000_0008, 32'h0000_0080, 32'h0000_1234, 4'd2, CB_ST,   0, 32'h0,        1'b1, 1'b0, 4'd0,  32'h0};
    vecs[3] = '{1'b1, 32'h0000_0100, 32'h0000_0777, 32'h0,        4'd7, CB_CALL, 0, 32'h0,        1'b0, 1'b1, 4'd15, 32'h0000_0104};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0123, 32'h0,        4'd1, CB_CALL, 0, 32'h0,        1'b0, 1'b1, 4'd15, 32'h0000_0000};
    vecs[5] = '{1'b0, 32'h0000_0200, 32'h0000_0040, 32'h0,        4'd6, CB_LD,   0, 32'h0,        1'b0, 1'b0, 4'd0,  32'h0};
    vecs[6] = '{1'b1, 32'h0000_0010, 32'h0000_CAFE, 32'h0000_5555, 4'd9, CB_ADD,  0, 32'h0,        1'b0, 1'b1, 4'd9,  32'h0000_CAFE};
    vecs[7] = '{1'b1, 32'h0000_0014, 32'h0000_0044, 32'h0,        4'd1, CB_LD,   1, 32'h0000_55AA, 1'b1, 1'b1, 4'd1,  32'h0000_55AA};

    rst_n     = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    drive_ex(1'b0, 32'd0, 32'd0, 32'd0, 4'd0, CB_NONE);

    // Writeback monitor: every rf_we pulse must match the head of the queue.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && rf_we) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_rf_we: got waddr=%0d wdata=%h expected no write", rf_waddr, rf_wdata);
          end else begin
            wb_t e;
            e = exp_q.pop_front();
            check("rf_waddr", {28'd0, rf_waddr}, {28'd0, e.waddr});
            check("rf_wdata", rf_wdata, e.wdata);
            check("fwd_rw_data", fwd_rw_data, e.wdata);
            $display("[TB] writeback r%0d = %h", rf_waddr, rf_wdata);
          end
        end
      end
    join_none

    // Reset state.
    #12;
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_stall", {31'd0, stall_out}, 32'd0);
    check("reset_rf_we", {31'd0, rf_we}, 32'd0);
    check("reset_retire", retire_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-transaction drops mem_req without a clock edge.
    @(negedge clk);
    drive_ex(1'b1, 32'h0000_0300, 32'h0000_0060, 32'd0, 4'd4, CB_LD);
    @(negedge clk);
    drive_ex(1'b0, 32'd0, 32'd0, 32'd0, 4'd0, CB_NONE);
    check("abort_mem_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_req_after", {31'd0, mem_req}, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_stall", {31'd0, stall_out}, 32'd0);
    check("abort_rf_we", {31'd0, rf_we}, 32'd0);
    $display("[TB] reset abort sequence done");

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Back-to-back loads with zero-wait memory: one completes as the next enters MA.
    @(negedge clk);
    drive_ex(1'b1, 32'h0000_0400, 32'h0000_0100, 32'd0, 4'd10, CB_LD);
    exp_q.push_back('{4'd10, 32'h1111_1111});
    @(negedge clk);
    drive_ex(1'b1, 32'h0000_0404, 32'h0000_0104, 32'd0, 4'd11, CB_LD);
    exp_q.push_back('{4'd11, 32'h2222_2222});
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_1111;
    #1;
    check("b2b_addr0", mem_addr, 32'h0000_0100);
    check("b2b_stall0", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    drive_ex(1'b0, 32'd0, 32'd0, 32'd0, 4'd0, CB_NONE);
    mem_rdata = 32'h2222_2222;
    #1;
    check("b2b_addr1", mem_addr, 32'h0000_0104);
    check("b2b_req1", {31'd0, mem_req}, 32'd1);
    check("b2b_fwd_isld", {31'd0, fwd_ma_isld}, 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    ret_exp = ret_exp + 32'd2;
    @(negedge clk);
    @(negedge clk);
    check("b2b_retire", retire_count, ret_exp);
    $display("[TB] back-to-back loads done");

    repeat (3) @(negedge clk);
    check("wb_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ma_rw_stage.md
Name: ma_rw_stage

Overview:
- Back end of the SimpleRisc pipeline: the memory-access (MA) and register-writeback (RW) stages that consume the EX-stage outputs.
- Holds the EX/MA and MA/RW pipeline registers and drives a request/ready data-memory port.
- Generates the register-file write port and the forwarding taps used by the OF/EX interlock logic.
- Asserts a stall upstream while a load or store waits on memory.

Parameters:
- CB_W, 22, control-bus width.
- CB_ISST, 0, control-bus bit index of isSt.
- CB_ISLD, 1, control-bus bit index of isLd.
- CB_ISWB, 6, control-bus bit index of isWb.
- CB_ISCALL, 8, control-bus bit index of isCall.
- RA_REG, 15, register written by call (return address).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset: 0 resets, 1 runs.
- ex_valid  in  1  EX output holds a real instruction (0 = bubble).
- output_EX_PC  in  32  PC of the EX instruction.
- ALU_Result  in  32  ALU result; also the memory address for ld/st.
- EX_op2  in  32  store data.
- output_EX_IR  in  32  instruction word; rd = IR[25:22].
- output_EX_controlBus  in  CB_W  decoded control bits.
- stall_out  out  1  EX must hold its outputs this cycle.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  store data.
- mem_ready  in  1  memory completes the request this cycle.
- mem_rdata  in  32  load data, valid when mem_ready=1.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  4  destination register.
- rf_wdata  out  32  write data.
- fwd_ma_valid, fwd_ma_rd, fwd_ma_isld  out  1/4/1  MA-stage forwarding tap.
- fwd_rw_valid, fwd_rw_rd, fwd_rw_data  out  1/4/32  RW-stage forwarding tap.
- retire_count  out  32  instructions retired through RW.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - ma_valid=0, state=MA_IDLE, rw_valid=0.
  - All outputs 0; mem_req drops immediately, even mid-transaction.
  - retire_count=0.
  - The pending memory transaction is abandoned; the memory side must tolerate this.
- FSM states: MA_IDLE (MA empty, or holding a non-memory op) and MA_REQ (holding ld/st, awaiting mem_ready).
- stall_out = (state==MA_REQ) & !mem_ready. Purely combinational; no registered bubble is inserted.
- EX/MA capture:
  - At the rising edge with stall_out=0, MA loads PC, ALU_Result, EX_op2, IR and controlBus, and sets ma_valid=ex_valid.
  - Next state: MA_REQ if ex_valid & (isLd|isSt), else MA_IDLE.
- MA_REQ outputs:
  - mem_req=1, mem_we=isSt, mem_addr=MA ALU_Result, mem_wdata=MA op2.
  - These are held stable until the cycle mem_ready=1.
  - Minimum MA latency is 1 cycle (mem_ready in the first MA_REQ cycle); there is no maximum.
- mem_ready outside MA_REQ is ignored. mem_req=0 in MA_IDLE.
- MA/RW capture at each rising edge with stall_out=0:
  - rw_valid <= ma_valid.
  - rw_isWb <= isWb.
  - rw_waddr <= isCall ? RA_REG : IR[25:22].
  - rw_data <= isLd ? mem_rdata : isCall ? PC+4 (mod 2^32) : ALU_Result.
- MA/RW capture while stall_out=1: rw_valid <= 0. The RW bubble prevents double writeback.
- Register-file write port (registered from the RW latch): rf_we = rw_valid & rw_isWb; rf_waddr = rw_waddr; rf_wdata = rw_data.
- Stores and branches reach RW with rf_we=0.
- retire_count increments by 1 at each edge where rw_valid=1, wrapping 0xFFFFFFFF -> 0.
- Forwarding taps:
  - fwd_ma_valid = ma_valid & isWb; fwd_ma_rd = the destination MA will write; fwd_ma_isld = isLd. A load in MA cannot be forwarded, so upstream must interlock.
  - fwd_rw_valid = rf_we; fwd_rw_rd = rf_waddr; fwd_rw_data = rf_wdata.
- Simultaneous events: in a cycle with MA_REQ and mem_ready=1, the load completes into RW and a new EX instruction enters MA on the same edge. Back-to-back memory ops therefore sustain 1 per cycle with zero-wait memory.
- A bubble (ex_valid=0) never issues mem_req, regardless of the controlBus contents.

Test Plan:
- Reset=0 asserted while in MA_REQ with mem_req=1 -> mem_req=0 with no clock edge; after release, stall_out=0 and rf_we=0.
- add r3 (ALU_Result=0x10, isWb) with ex_valid=1 -> 2 edges later rf_we=1, rf_waddr=3, rf_wdata=0x10; retire_count=1.
- ld r5, addr 0x40, with mem_ready held 0 for 3 cycles then 1 and mem_rdata=0xDEADBEEF:
  - stall_out=1 for exactly 3 cycles; mem_addr=0x40 and mem_we=0 stable throughout.
  - Next edge: rf_wdata=0xDEADBEEF, rf_waddr=5; only one rf_we pulse.
- st, addr 0x80, EX_op2=0x1234, zero-wait memory -> mem_req=1, mem_we=1, mem_wdata=0x1234 for one cycle; rf_we stays 0; retire_count still increments.
- call at PC=0x100 -> rf_waddr=15, rf_wdata=0x104.
- call at PC=0xFFFFFFFC -> rf_wdata=0x0.
- ex_valid=0 with isLd=1 in controlBus -> mem_req never asserts, and retire_count is unchanged.
